mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the pipeline MEM stage.
- Owns a word-organised data memory with a configurable access latency (wait states).
- Adds byte access and an address-range / alignment check.
- Drives a `ready` handshake that freezes the pipeline until each access completes.
- Sits between EXE/MEM and MEM/WB pipeline registers. Control and result fields pass through unchanged.

Parameters:
- DATA_W, 32, register / data word width (multiple of 8)
- DEST_W, 4, destination register address width
- MEM_WORDS, 64, number of data words (power of two)
- BASE_ADDR, 1024, byte address of word 0
- WAIT_CYCLES, 3, cycles from request to completion (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_en_in  in  1  write-back enable from EXE
- mem_r_en_in  in  1  load request
- mem_w_en_in  in  1  store request
- size_in  in  1  0 = word access, 1 = byte access
- alu_res_in  in  DATA_W  effective byte address / ALU result
- val_Rm  in  DATA_W  store data
- dest_in  in  DEST_W  destination register
- wb_en_out  out  1  = wb_en_in (combinational)
- mem_r_en_out  out  1  = mem_r_en_in (combinational)
- alu_res_out  out  DATA_W  = alu_res_in (combinational)
- dest_out  out  DEST_W  = dest_in (combinational)
- mem_out  out  DATA_W  registered load data
- ready  out  1  1 = stage may advance this cycle
- addr_err  out  1  1 = current request rejected (range/alignment)

Behaviour:

Request and index
- req = mem_r_en_in | mem_w_en_in.
- If both enables are high, the access is a store (write priority).
- off = alu_res_in - BASE_ADDR. Word index = off[log2(MEM_WORDS)+1:2]. Byte lane = off[1:0].

Validity check
- A request is invalid if alu_res_in < BASE_ADDR, or off >= 4*MEM_WORDS, or (size_in=0 and off[1:0] != 0).
- addr_err = (state==IDLE) & req & invalid. It is combinational.
- An invalid request performs no access and leaves mem_out unchanged. ready stays 1, so the instruction proceeds with no memory effect.

FSM states: IDLE, WAIT, DONE.
- IDLE: ready = ~(req & ~invalid). On a valid req, latch wcnt=1 and go to WAIT.
  - If WAIT_CYCLES==1, go directly to DONE and perform the access at that edge.
- WAIT: ready=0. wcnt increments each cycle. When wcnt==WAIT_CYCLES-1, perform the access at the edge and go to DONE.
- DONE: ready=1. Unconditionally return to IDLE next edge.
  - Inputs are still held, since the pipeline was frozen until ready rose. They must not start a new access in DONE.
- Latency: a valid request first seen in cycle 0 gives ready=1 in cycle WAIT_CYCLES. Upstream advances on the edge ending that cycle.

Access semantics (at the completing edge)
- Word store: mem[idx] <= val_Rm.
- Byte store: only lane off[1:0] of mem[idx] is replaced with val_Rm[7:0]. Other lanes are unchanged (read-modify-write).
- Word load: mem_out <= mem[idx].
- Byte load: mem_out <= zero-extended selected byte.
- A store leaves mem_out unchanged.
- mem_out holds its last load value indefinitely.

Reset (rst=0, asynchronous)
- state=IDLE, wcnt=0, mem_out=0. ready and addr_err follow from IDLE and the inputs.
- Memory array contents are not reset.
- Reset during WAIT aborts the access: no store is committed, mem_out is unchanged from 0.

Back-to-back requests
- Each request costs WAIT_CYCLES cycles in WAIT/DONE plus no IDLE bubble. A new request is recognised in the IDLE cycle following DONE.

Decomposition:
- Shared Defines package gains MEM_SIZE_WORD/MEM_SIZE_BYTE constants and the FSM state encoding (2 bits).
- One natural sub-module, mem_wait_fsm: holds state and wcnt, and outputs the `ready` and `commit` strobes.
- The top level holds the array, lane merge/extract, range check and pass-throughs.

Test Plan:
- Word store 0xDEADBEEF to 1024, then word load from 1024, WAIT_CYCLES=3:
  - store: ready low in cycles 0-2, high in cycle 3.
  - load: mem_out=0xDEADBEEF from the cycle-3 edge.
- Byte store 0x5A to 1029 over existing 0x11223344 at 1028, then word load 1028 -> 0x11225A44; byte load 1029 -> 0x0000005A.
- Word load from 1026 (misaligned), from 1000, and from 1024+4*MEM_WORDS:
  - addr_err=1, ready=1 the same cycle.
  - mem_out and memory unchanged.
- Assert rst=0 in cycle 1 of a store of 0xCAFEF00D to 1032; later load from 1032 -> previous contents (not 0xCAFEF00D); mem_out=0 right after reset.
- Both mem_r_en_in and mem_w_en_in high with val_Rm=0x12345678 at 1040 -> treated as store; subsequent load returns 0x12345678.
- WAIT_CYCLES=1 build with back-to-back loads from 1024 and 1028 -> ready pattern 0,1,0,1; each value appears in mem_out one cycle after its request.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: access-size codes and
// the wait-state FSM encoding.
package mem_access_unit_pkg;

  localparam logic MEM_SIZE_WORD = 1'b0;
  localparam logic MEM_SIZE_BYTE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state sequencer for the memory stage. It accepts a validated request,
// counts out the access latency, and emits one commit strobe on the edge
// where the access takes effect. The ready output is the stall release.
module mem_wait_fsm
  import mem_access_unit_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic commit,
  output logic idle
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  mau_state_t state, state_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;

  // State and wait counter registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // Next-state, counter and strobe decode. DONE never starts a new access
  // because the frozen pipeline still presents the completed request.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    ready   = 1'b0;
    commit  = 1'b0;
    idle    = 1'b0;
    case (state)
      ST_IDLE: begin
        idle  = 1'b1;
        ready = ~start;
        if (start) begin
          wcnt_n = CNT_W'(1);
          if (WAIT_CYCLES == 1) begin
            commit  = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt == LAST) begin
          commit  = 1'b1;
          state_n = ST_DONE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        wcnt_n  = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage with wait states: word-organised data memory, byte lanes,
// address range/alignment check and a ready handshake that stalls the pipe.
// Control and ALU result fields pass straight through to MEM/WB.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEST_W      = 4,
  parameter int MEM_WORDS   = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              size_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_Rm,
  input  logic [DEST_W-1:0] dest_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] mem_out,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] SPAN = DATA_W'(4 * MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [DATA_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              req;
  logic              invalid;
  logic              start;
  logic              commit;
  logic              idle;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] load_val;
  logic [7:0]        load_byte;

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  assign req     = mem_r_en_in | mem_w_en_in;
  assign off     = alu_res_in - BASE;
  assign idx     = off[IDX_W+1:2];
  assign lane    = off[1:0];
  assign invalid = (alu_res_in < BASE) | (off >= SPAN) |
                   ((size_in == MEM_SIZE_WORD) & (lane != 2'b00));
  assign start    = req & ~invalid;
  assign addr_err = idle & req & invalid;
  assign cur_word = mem[idx];

  mem_wait_fsm #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ready  (ready),
    .commit (commit),
    .idle   (idle)
  );

  // Byte-lane merge for stores and lane extract for byte loads.
  always_comb begin
    merged                     = cur_word;
    merged[{lane, 3'b000} +: 8] = val_Rm[7:0];
    load_byte                  = cur_word[{lane, 3'b000} +: 8];
    store_word = (size_in == MEM_SIZE_BYTE) ? merged : val_Rm;
    load_val   = (size_in == MEM_SIZE_BYTE) ? {{(DATA_W-8){1'b0}}, load_byte} : cur_word;
  end

  // Store commit; the array itself is never cleared, and a reset edge
  // suppresses any pending write.
  always_ff @(posedge clk) begin
    if (commit && rst && mem_w_en_in) begin
      mem[idx] <= store_word;
    end
  end

  // Load data register; stores (including read+write requests) leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_out <= '0;
    end else if (commit && !mem_w_en_in) begin
      mem_out <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance with three wait states,
// one with a single wait state. Drivers queue expected completions; a
// negedge monitor checks latency, addr_err and mem_out at each completion.
module tb_mem_access_unit;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] out;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        r0, w0, sz0, r1, w1, sz1;
  logic [31:0] a0, d0, a1, d1;
  logic        wbo0, mro0, wbo1, mro1;
  logic [31:0] alo0, alo1, mem_out0, mem_out1;
  logic [3:0]  dso0, dso1;
  logic        ready0, ready1, addr_err0, addr_err1;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt0  = 0;
  int   cnt1  = 0;
  logic [3:0] hist;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .wb_en_in(1'b1), .mem_r_en_in(r0), .mem_w_en_in(w0),
    .size_in(sz0), .alu_res_in(a0), .val_Rm(d0), .dest_in(4'd3),
    .wb_en_out(wbo0), .mem_r_en_out(mro0), .alu_res_out(alo0), .dest_out(dso0),
    .mem_out(mem_out0), .ready(ready0), .addr_err(addr_err0)
  );

  mem_access_unit #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wb_en_in(1'b0), .mem_r_en_in(r1), .mem_w_en_in(w1),
    .size_in(sz1), .alu_res_in(a1), .val_Rm(d1), .dest_in(4'd9),
    .wb_en_out(wbo1), .mem_r_en_out(mro1), .alu_res_out(alo1), .dest_out(dso1),
    .mem_out(mem_out1), .ready(ready1), .addr_err(addr_err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int sel, input int lat, input logic err, input logic [31:0] out);
    exp_t e;
    int   empty;
    empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty != 0) begin
      tests++;
      fails++;
      $display("FAIL dut%0d_unexpected_completion: got mem_out 0x%08h expected no completion", sel, out);
    end else begin
      if (sel == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      check($sformatf("dut%0d_%s_latency", sel, e.name), lat, e.lat);
      check($sformatf("dut%0d_%s_addr_err", sel, e.name), {31'd0, err}, {31'd0, e.err});
      check($sformatf("dut%0d_%s_mem_out", sel, e.name), out, e.out);
    end
  endtask

  // Completion monitor: counts cycles of each request and checks when ready rises.
  always @(negedge clk) begin
    if (!rst) begin
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      if (r0 | w0) begin
        if (ready0) begin
          pop_check(0, cnt0, addr_err0, mem_out0);
          cnt0 = 0;
        end else cnt0++;
      end
      if (r1 | w1) begin
        if (ready1) begin
          pop_check(1, cnt1, addr_err1, mem_out1);
          cnt1 = 0;
        end else cnt1++;
      end
    end
  end

  task automatic acc(input int sel, input logic r, input logic w, input logic sz,
                     input logic [31:0] addr, input logic [31:0] data,
                     input int lat, input logic err, input logic [31:0] out, input string name);
    exp_t e;
    logic rdy;
    bit   done;
    e.lat = lat; e.err = err; e.out = out; e.name = name;
    if (sel == 0) begin
      q0.push_back(e);
      r0 = r; w0 = w; sz0 = sz; a0 = addr; d0 = data;
    end else begin
      q1.push_back(e);
      r1 = r; w1 = w; sz1 = sz; a1 = addr; d1 = data;
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      rdy  = (sel == 0) ? ready0 : ready1;
      hist = {hist[2:0], rdy};
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL dut%0d_%s_timeout: got no ready in 20 cycles expected ready", sel, name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    r0 = 1'b0; w0 = 1'b0; r1 = 1'b0; w1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    hist = 4'd0;
    r0 = 0; w0 = 0; sz0 = 0; a0 = 0; d0 = 0;
    r1 = 0; w1 = 0; sz1 = 0; a1 = 0; d1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_out0", mem_out0, 32'h0);
    check("reset_mem_out1", mem_out1, 32'h0);
    check("reset_ready0", {31'd0, ready0}, 32'd1);
    check("reset_addr_err0", {31'd0, addr_err0}, 32'd0);
    check("passthru_alu", alo0, a0);
    check("passthru_dest", {28'd0, dso1}, 32'd9);
    rst = 1'b1;
    @(posedge clk);
    #1;

    acc(0, 0, 1, 0, 1024, 32'hDEADBEEF, 3, 0, 32'h00000000, "st_w_1024");
    acc(0, 1, 0, 0, 1024, 32'h0,        3, 0, 32'hDEADBEEF, "ld_w_1024");
    acc(0, 0, 1, 0, 1028, 32'h11223344, 3, 0, 32'hDEADBEEF, "st_w_1028");
    acc(0, 0, 1, 1, 1029, 32'hFFFFFF5A, 3, 0, 32'hDEADBEEF, "st_b_1029");
    acc(0, 1, 0, 0, 1028, 32'h0,        3, 0, 32'h11225A44, "ld_w_1028_merged");
    acc(0, 1, 0, 1, 1029, 32'h0,        3, 0, 32'h0000005A, "ld_b_1029");
    acc(0, 1, 0, 1, 1031, 32'h0,        3, 0, 32'h00000011, "ld_b_1031");
    acc(0, 1, 0, 0, 1026, 32'h0,        0, 1, 32'h00000011, "ld_w_misaligned");
    acc(0, 1, 0, 0, 1000, 32'h0,        0, 1, 32'h00000011, "ld_w_below_base");
    acc(0, 1, 0, 0, 1280, 32'h0,        0, 1, 32'h00000011, "ld_w_past_end");
    acc(0, 0, 1, 0, 1026, 32'h0,        0, 1, 32'h00000011, "st_w_misaligned");
    acc(0, 1, 0, 0, 1024, 32'h0,        3, 0, 32'hDEADBEEF, "ld_w_1024_intact");
    acc(0, 1, 0, 0, 1028, 32'h0,        3, 0, 32'h11225A44, "ld_w_1028_intact");
    acc(0, 0, 1, 1, 1279, 32'h00000077, 3, 0, 32'h11225A44, "st_b_last");
    acc(0, 1, 0, 1, 1279, 32'h0,        3, 0, 32'h00000077, "ld_b_last");
    acc(0, 0, 1, 0, 1032, 32'hA5A5A5A5, 3, 0, 32'h00000077, "st_w_1032");
    idle_all();

    // Store of 0xCAFEF00D aborted by reset in its second cycle.
    w0 = 1'b1; r0 = 1'b0; sz0 = 1'b0; a0 = 1032; d0 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rst = 1'b0;
    w0  = 1'b0;
    #1;
    check("abort_mem_out", mem_out0, 32'h0);
    check("abort_ready", {31'd0, ready0}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_mem_out", mem_out0, 32'h0);

    acc(0, 1, 0, 0, 1032, 32'h0,        3, 0, 32'hA5A5A5A5, "ld_w_1032_not_aborted");
    acc(0, 1, 1, 0, 1040, 32'h12345678, 3, 0, 32'hA5A5A5A5, "rw_both_is_store");
    acc(0, 1, 0, 0, 1040, 32'h0,        3, 0, 32'h12345678, "ld_w_1040");
    acc(0, 1, 0, 1, 1280, 32'h0,        0, 1, 32'h12345678, "ld_b_past_end");
    idle_all();
    @(posedge clk);
    #1;

    acc(1, 0, 1, 0, 1024, 32'h01010101, 1, 0, 32'h00000000, "st_w_1024");
    acc(1, 0, 1, 0, 1028, 32'h02020202, 1, 0, 32'h00000000, "st_w_1028");
    hist = 4'd0;
    acc(1, 1, 0, 0, 1024, 32'h0,        1, 0, 32'h01010101, "b2b_ld_1024");
    acc(1, 1, 0, 0, 1028, 32'h0,        1, 0, 32'h02020202, "b2b_ld_1028");
    idle_all();
    check("b2b_ready_pattern", {28'd0, hist}, 32'h5);

    repeat (3) @(negedge clk);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
